// File: rtl/fifo_rd_sched_pkg.sv
// Shared definitions for the UART TX FIFO read-side scheduler:
// FSM state encoding and the default widths.
package fifo_rd_sched_pkg;

   localparam int DEF_D_WIDTH = 8;
   localparam int DEF_GAP_W   = 8;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_POP       = 3'd1,
      ST_SEND      = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_GAP       = 3'd5
   } state_t;

endpackage

// File: rtl/fifo_rd_sched.sv
// Read-domain scheduler: pops one FIFO word, hands it to UART TX with a valid
// pulse, follows the transmitter's busy cycle, then waits out the inter-frame gap.
module fifo_rd_sched
   import fifo_rd_sched_pkg::*;
#(
   parameter int D_WIDTH = DEF_D_WIDTH,
   parameter int GAP_W   = DEF_GAP_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               r_clk,
   input  logic               rrst_n,
   input  logic               en,
   input  logic [GAP_W-1:0]   gap_cfg,
   input  logic               r_empty,
   input  logic [D_WIDTH-1:0] rd_data,
   output logic               r_inc,
   input  logic               tx_busy,
   output logic [D_WIDTH-1:0] tx_data,
   output logic               tx_valid,
   output logic               active,
   output logic [CNT_W-1:0]   frame_cnt
);

   state_t             r_state;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic               r_pop;
   logic               r_tx_valid;
   logic               r_active;
   logic [D_WIDTH-1:0] r_tx_data;
   logic [CNT_W-1:0]   r_frame_cnt;

   // r_empty lags a pop by one cycle; it is only looked at in IDLE, which is
   // always at least three cycles after the pop strobe.
   always_ff @(posedge r_clk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state     <= ST_IDLE;
         r_gap_cnt   <= '0;
         r_pop       <= 1'b0;
         r_tx_valid  <= 1'b0;
         r_active    <= 1'b0;
         r_tx_data   <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_pop      <= 1'b0;
         r_tx_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (en && !r_empty && !tx_busy) begin
                  r_tx_data <= rd_data;
                  r_pop     <= 1'b1;
                  r_active  <= 1'b1;
                  r_state   <= ST_POP;
               end
            end
            ST_POP: begin
               r_tx_valid <= 1'b1;
               r_state    <= ST_SEND;
            end
            ST_SEND: begin
               r_frame_cnt <= r_frame_cnt + CNT_W'(1);
               r_state     <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (tx_busy) begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (gap_cfg == '0) begin
                     r_active <= 1'b0;
                     r_state  <= ST_IDLE;
                  end else begin
                     // gap_cfg-1 down to 0 inclusive gives gap_cfg idle cycles
                     r_gap_cnt <= gap_cfg - GAP_W'(1);
                     r_state   <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_active <= 1'b0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               r_active <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign r_inc     = r_pop;
   assign tx_valid  = r_tx_valid;
   assign tx_data   = r_tx_data;
   assign active    = r_active;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Self-checking bench for fifo_rd_sched: FIFO and UART TX models, a timeline
// model of pop/valid/active/data/count checked every cycle, plus directed checks.
module tb_fifo_rd_sched;

   localparam int DW  = 8;
   localparam int GW  = 8;
   localparam int CW  = 4;
   localparam int BIG = 32'h3fffffff;

   logic          r_clk = 1'b0;
   logic          rrst_n = 1'b0;
   logic          en = 1'b0;
   logic [GW-1:0] gap_cfg = '0;
   logic          r_empty = 1'b1;
   logic [DW-1:0] rd_data = '0;
   logic          auto_busy = 1'b0;
   logic          tx_hold = 1'b0;
   logic          tx_busy;
   logic          r_inc;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          active;
   logic [CW-1:0] frame_cnt;

   assign tx_busy = auto_busy | tx_hold;

   fifo_rd_sched #(.D_WIDTH(DW), .GAP_W(GW), .CNT_W(CW)) dut (
      .r_clk     (r_clk),
      .rrst_n    (rrst_n),
      .en        (en),
      .gap_cfg   (gap_cfg),
      .r_empty   (r_empty),
      .rd_data   (rd_data),
      .r_inc     (r_inc),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .active    (active),
      .frame_cnt (frame_cnt)
   );

   always #5 r_clk = ~r_clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            inc_cnt = 0;
   int            busy_len = 10;
   int            fall_cyc = -1000;
   logic          prev_busy = 1'b0;
   logic [DW-1:0] q[$];
   int            meas_q[$];

   // timeline model: cycle of the pop strobe, first cycle back in IDLE
   int            m_pop = -100;
   int            m_idle_at = 0;
   logic          m_seen_busy = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic [CW-1:0] m_cnt = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // FIFO model: pop lands on the edge after r_inc, flags are registered
   initial begin
      logic pend;
      forever begin
         @(negedge r_clk);
         pend = r_inc && rrst_n;
         @(posedge r_clk);
         #1;
         if (pend && q.size() > 0) void'(q.pop_front());
         r_empty = (q.size() == 0);
         rd_data = (q.size() > 0) ? q[0] : '0;
      end
   end

   // UART TX model: busy rises 2 cycles after valid, lasts busy_len cycles
   initial begin
      forever begin
         @(negedge r_clk);
         if (tx_valid && rrst_n) begin
            @(posedge r_clk);
            @(posedge r_clk);
            #1 auto_busy = 1'b1;
            repeat (busy_len) @(posedge r_clk);
            #1 auto_busy = 1'b0;
         end
      end
   end

   // Per-cycle compare against the timeline model
   initial begin
      forever begin
         @(negedge r_clk);
         cyc++;
         if (!rrst_n) begin
            chk("rst_r_inc", {31'd0, r_inc}, 32'd0);
            chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
            chk("rst_active", {31'd0, active}, 32'd0);
            chk("rst_tx_data", 32'(tx_data), 32'd0);
            chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
            m_pop = -100; m_idle_at = 0; m_seen_busy = 1'b0;
            m_data = '0; m_cnt = '0;
         end else begin
            chk("r_inc", {31'd0, r_inc}, {31'd0, cyc == m_pop});
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, cyc == m_pop + 1});
            chk("active", {31'd0, active}, {31'd0, (cyc >= m_pop) && (cyc < m_idle_at)});
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
            if (prev_busy && !tx_busy) fall_cyc = cyc;
            if (r_inc) begin
               inc_cnt++;
               meas_q.push_back(cyc - fall_cyc);
            end
            if (cyc == m_pop + 1) m_cnt = m_cnt + 1'b1;
            if (cyc >= m_idle_at) begin
               if (en && !r_empty && !tx_busy) begin
                  m_pop = cyc + 1;
                  m_data = rd_data;
                  m_idle_at = BIG;
                  m_seen_busy = 1'b0;
               end
            end else if (m_idle_at == BIG && cyc >= m_pop + 2) begin
               if (!m_seen_busy) begin
                  if (tx_busy) m_seen_busy = 1'b1;
               end else if (!tx_busy) begin
                  m_idle_at = cyc + 1 + int'(gap_cfg);
               end
            end
         end
         prev_busy = tx_busy;
      end
   end

   task automatic wait_valid(input string nm);
      int k;
      for (k = 0; k < 100; k++) begin
         @(negedge r_clk);
         #1;
         if (tx_valid) break;
      end
      if (k == 100) begin
         n_cmp++; n_bad++;
         $display("FAIL %s timeout got=no_valid expected=valid", nm);
      end else begin
         $display("frame %s: tx_data=%02h frame_cnt=%0d cyc=%0d", nm, tx_data, frame_cnt, cyc);
      end
   endtask

   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge r_clk);
         #1;
         if (!active && !tx_busy) break;
      end
      if (k == 300) begin
         n_cmp++; n_bad++;
         $display("FAIL %s idle_timeout got=active expected=idle", nm);
      end
   endtask

   task automatic do_reset();
      for (int k = 0; k < 100 && auto_busy; k++) @(posedge r_clk);
      @(posedge r_clk);
      #2 rrst_n = 1'b0;
      en = 1'b0;
      q.delete();
      repeat (2) @(posedge r_clk);
      #1 rrst_n = 1'b1;
   endtask

   initial begin
      int base;
      repeat (3) @(posedge r_clk);
      #1 rrst_n = 1'b1;

      // single word, no gap, long busy
      do_reset();
      busy_len = 10; gap_cfg = 8'd0;
      q.push_back(8'hA5);
      en = 1'b1;
      base = inc_cnt;
      wait_valid("t1");
      chk("t1_data", 32'(tx_data), 32'h0000_00A5);
      wait_idle("t1");
      repeat (10) @(negedge r_clk);
      #1;
      chk("t1_cnt", 32'(frame_cnt), 32'd1);
      chk("t1_pops", inc_cnt - base, 32'd1);
      chk("t1_active", {31'd0, active}, 32'd0);

      // three words in order with a 4-cycle gap
      do_reset();
      busy_len = 3; gap_cfg = 8'd4;
      q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03);
      meas_q.delete();
      en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         wait_valid("t2");
         chk("t2_order", 32'(tx_data), i);
      end
      wait_idle("t2");
      #1;
      chk("t2_cnt", 32'(frame_cnt), 32'd3);
      chk("t2_npops", meas_q.size(), 32'd3);
      if (meas_q.size() == 3) begin
         chk("t2_gap1", meas_q[1], 32'd6);
         chk("t2_gap2", meas_q[2], 32'd6);
      end

      // enable held low with data waiting, then raised
      do_reset();
      busy_len = 2; gap_cfg = 8'd0;
      q.push_back(8'h11);
      base = inc_cnt;
      repeat (50) @(negedge r_clk);
      #1;
      chk("t3_no_pop", inc_cnt - base, 32'd0);
      @(posedge r_clk);
      #1 en = 1'b1;
      repeat (2) @(negedge r_clk);
      #1;
      chk("t3_pop", inc_cnt - base, 32'd1);
      wait_idle("t3");

      // enable dropped mid-frame: frame and gap finish, data left behind
      busy_len = 4; gap_cfg = 8'd3;
      q.push_back(8'h44); q.push_back(8'h55);
      base = inc_cnt;
      wait_valid("t4");
      @(posedge r_clk);
      #1 en = 1'b0;
      wait_idle("t4");
      repeat (20) @(negedge r_clk);
      #1;
      chk("t4_pops", inc_cnt - base, 32'd1);
      chk("t4_left", q.size(), 32'd1);
      chk("t4_active", {31'd0, active}, 32'd0);

      // transmitter busy while idle blocks the pop
      tx_hold = 1'b1;
      @(posedge r_clk);
      #1 en = 1'b1;
      repeat (10) @(negedge r_clk);
      #1;
      chk("t4_busy_hold", inc_cnt - base, 32'd1);
      @(posedge r_clk);
      #1 tx_hold = 1'b0;
      repeat (2) @(negedge r_clk);
      #1;
      chk("t4_busy_rel", inc_cnt - base, 32'd2);
      wait_idle("t4b");

      // async reset during WAIT_DONE, then nothing to pop
      busy_len = 10; gap_cfg = 8'd2;
      q.push_back(8'h3C);
      wait_valid("t5");
      repeat (4) @(posedge r_clk);
      #3 rrst_n = 1'b0;
      #1;
      chk("t5_r_inc", {31'd0, r_inc}, 32'd0);
      chk("t5_valid", {31'd0, tx_valid}, 32'd0);
      chk("t5_data", 32'(tx_data), 32'd0);
      chk("t5_active", {31'd0, active}, 32'd0);
      chk("t5_cnt", 32'(frame_cnt), 32'd0);
      repeat (2) @(posedge r_clk);
      #1 rrst_n = 1'b1;
      base = inc_cnt;
      repeat (20) @(negedge r_clk);
      #1;
      chk("t5_stay_idle", inc_cnt - base, 32'd0);
      chk("t5_idle_active", {31'd0, active}, 32'd0);

      // frame counter wrap (4-bit counter, 16 frames)
      do_reset();
      busy_len = 1; gap_cfg = 8'd0;
      for (int i = 0; i < 16; i++) q.push_back(DW'(8'h80 + i));
      en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         wait_valid("t6");
         @(negedge r_clk);
         #1;
         chk("t6_cnt", 32'(frame_cnt), i % 16);
      end
      wait_idle("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
